// File: rtl/button_counter.sv
// Debounced four-button up/down counter (BCD or hex) driving a multiplexed
// active-low seven-segment display.
module button_counter #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned DEB_CYCLES     = 250000,
   parameter int unsigned REFRESH_CYCLES = 25000,
   parameter bit          BLANK_LZ       = 1'b1
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [3:0]  iBtns,
   output logic [3:0]  oAN,
   output logic [7:0]  oC,
   output logic [15:0] oCount,
   output logic        oMode
);

   localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
   localparam int unsigned RefW = $clog2(REFRESH_CYCLES);
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
   localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);
   localparam logic [1:0]      IdxLast = 2'(NUM_DIGITS - 1);

   logic [3:0]            sync1_q, sync2_q;
   logic [3:0]            deb_q, deb_d, deb_dly_q;
   logic [3:0]            arm_q, arm_d;
   logic [3:0]            pulse_q, pulse_d;
   logic [3:0][DebW-1:0]  dcnt_q, dcnt_d;
   logic [1:0]            vld_q;
   logic [15:0]           cnt_q, cnt_d, mask;
   logic                  mode_q, mode_d;
   logic [RefW-1:0]       ref_q, ref_d;
   logic [1:0]            idx_q, idx_d;
   logic [3:0]            an_q, an_d;
   logic [7:0]            c_q, c_d;
   logic                  carry;
   logic [3:0]            dig, disp_nib;
   logic                  disp_blank;

   function automatic logic [6:0] seg_glyph(input logic [3:0] v);
      case (v)
         4'h0:    seg_glyph = 7'h40;
         4'h1:    seg_glyph = 7'h79;
         4'h2:    seg_glyph = 7'h24;
         4'h3:    seg_glyph = 7'h30;
         4'h4:    seg_glyph = 7'h19;
         4'h5:    seg_glyph = 7'h12;
         4'h6:    seg_glyph = 7'h02;
         4'h7:    seg_glyph = 7'h78;
         4'h8:    seg_glyph = 7'h00;
         4'h9:    seg_glyph = 7'h10;
         4'hA:    seg_glyph = 7'h08;
         4'hB:    seg_glyph = 7'h03;
         4'hC:    seg_glyph = 7'h46;
         4'hD:    seg_glyph = 7'h21;
         4'hE:    seg_glyph = 7'h06;
         default: seg_glyph = 7'h0E;
      endcase
   endfunction

   always_comb begin
      deb_d  = deb_q;
      dcnt_d = dcnt_q;
      for (int b = 0; b < 4; b++) begin
         if (sync2_q[b] == deb_q[b]) begin
            dcnt_d[b] = '0;
         end else if (dcnt_q[b] == DebLast) begin
            deb_d[b]  = sync2_q[b];
            dcnt_d[b] = '0;
         end else begin
            dcnt_d[b] = dcnt_q[b] + DebW'(1);
         end
      end
   end

   // A button must be seen released after reset before its presses count.
   always_comb begin
      arm_d   = arm_q | ({4{vld_q[1]}} & ~sync2_q);
      pulse_d = deb_q & ~deb_dly_q & arm_q;
   end

   always_comb begin
      cnt_d  = cnt_q;
      mode_d = mode_q;
      carry  = 1'b1;
      dig    = '0;
      mask   = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(NUM_DIGITS)) mask[4*k +: 4] = 4'hF;
      end
      if (pulse_q[2] | pulse_q[3]) begin
         cnt_d  = '0;
         mode_d = mode_q ^ pulse_q[3];
      end else if (pulse_q[0] ^ pulse_q[1]) begin
         if (mode_q) begin
            cnt_d = (pulse_q[0] ? cnt_q + 16'd1 : cnt_q - 16'd1) & mask;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (k < int'(NUM_DIGITS) && carry) begin
                  dig = cnt_q[4*k +: 4];
                  if (pulse_q[0]) begin
                     carry            = (dig == 4'd9);
                     cnt_d[4*k +: 4]  = carry ? 4'd0 : dig + 4'd1;
                  end else begin
                     carry            = (dig == 4'd0);
                     cnt_d[4*k +: 4]  = carry ? 4'd9 : dig - 4'd1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      ref_d      = ref_q + RefW'(1);
      idx_d      = idx_q;
      an_d       = an_q;
      c_d        = c_q;
      disp_nib   = '0;
      disp_blank = 1'b0;
      if (ref_q == RefLast) begin
         ref_d      = '0;
         idx_d      = (idx_q == IdxLast) ? 2'd0 : idx_q + 2'd1;
         an_d       = ~(4'b0001 << idx_d);
         disp_nib   = cnt_q[{idx_d, 2'b00} +: 4];
         disp_blank = BLANK_LZ && (idx_d != 2'd0) && ((cnt_q >> {idx_d, 2'b00}) == 16'd0);
         c_d        = {~(mode_q && (idx_d == 2'd0)),
                       disp_blank ? 7'h7F : seg_glyph(disp_nib)};
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         arm_q     <= '0;
         pulse_q   <= '0;
         dcnt_q    <= '0;
         vld_q     <= '0;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         ref_q     <= '0;
         idx_q     <= '0;
         an_q      <= 4'hF;
         c_q       <= 8'hFF;
      end else begin
         sync1_q   <= iBtns;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         arm_q     <= arm_d;
         pulse_q   <= pulse_d;
         dcnt_q    <= dcnt_d;
         vld_q     <= {vld_q[0], 1'b1};
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         ref_q     <= ref_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         c_q       <= c_d;
      end
   end

   assign oAN    = an_q;
   assign oC     = c_q;
   assign oCount = cnt_q;
   assign oMode  = mode_q;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with short debounce and refresh periods.
module tb_button_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  btns = 4'h0;
   logic [3:0]  an;
   logic [7:0]  c;
   logic [15:0] count;
   logic        mode;
   int          n_checks = 0;
   int          n_fails  = 0;

   button_counter #(
      .NUM_DIGITS(2),
      .DEB_CYCLES(4),
      .REFRESH_CYCLES(3),
      .BLANK_LZ(1'b1)
   ) dut (
      .iClk(clk),
      .iRst(rst),
      .iBtns(btns),
      .oAN(an),
      .oC(c),
      .oCount(count),
      .oMode(mode)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] b);
      btns = b;
      tick(10);
      btns = 4'h0;
      tick(10);
   endtask

   // Scan the display and compare each digit's cathodes against its expected pattern.
   task automatic check_display(input string tag, input logic [7:0] exp_d0,
                                input logic [7:0] exp_d1);
      bit seen0 = 1'b0;
      bit seen1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         check_eq({tag, "_an_hi"}, {30'd0, an[3:2]}, 32'h3);
         if (an == 4'b1110) begin
            seen0 = 1'b1;
            check_eq({tag, "_d0"}, {24'd0, c}, {24'd0, exp_d0});
         end else if (an == 4'b1101) begin
            seen1 = 1'b1;
            check_eq({tag, "_d1"}, {24'd0, c}, {24'd0, exp_d1});
         end else begin
            check_eq({tag, "_an_onehot"}, {28'd0, an}, 32'hE);
         end
      end
      check_eq({tag, "_seen_d0"}, {31'd0, seen0}, 32'd1);
      check_eq({tag, "_seen_d1"}, {31'd0, seen1}, 32'd1);
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      check_eq("rst_an", {28'd0, an}, 32'hF);
      check_eq("rst_c", {24'd0, c}, 32'hFF);
      check_eq("rst_count", {16'd0, count}, 32'h0);
      check_eq("rst_mode", {31'd0, mode}, 32'h0);
      tick(3);
      rst = 1'b0;
      tick(5);

      // Single clean press: edge first sampled on the next rising edge, result 7 edges later.
      btns = 4'b0001;
      tick(7);
      check_eq("inc_latency_early", {16'd0, count}, 32'h00);
      tick(1);
      check_eq("inc_latency_hit", {16'd0, count}, 32'h01);
      tick(2);
      btns = 4'h0;
      tick(10);
      check_eq("inc_single_step", {16'd0, count}, 32'h01);

      for (int i = 0; i < 10; i++) begin
         btns[0] = ~btns[0];
         tick(2);
      end
      tick(10);
      check_eq("bounce_ignored", {16'd0, count}, 32'h01);

      press(4'b0010);
      check_eq("bcd_dec_to_0", {16'd0, count}, 32'h00);
      press(4'b0010);
      check_eq("bcd_wrap_dn", {16'd0, count}, 32'h99);
      press(4'b0001);
      check_eq("bcd_wrap_up", {16'd0, count}, 32'h00);
      press(4'b0010);
      check_eq("bcd_wrap_dn2", {16'd0, count}, 32'h99);
      press(4'b0001);
      for (int i = 0; i < 10; i++) press(4'b0001);
      check_eq("bcd_carry", {16'd0, count}, 32'h10);
      press(4'b0010);
      check_eq("bcd_borrow", {16'd0, count}, 32'h09);
      press(4'b0011);
      check_eq("inc_dec_cancel", {16'd0, count}, 32'h09);

      press(4'b0100);
      check_eq("clear", {16'd0, count}, 32'h00);
      check_eq("clear_mode", {31'd0, mode}, 32'h0);
      for (int i = 0; i < 5; i++) press(4'b0001);
      check_eq("count_5", {16'd0, count}, 32'h05);
      check_display("blank", 8'h92, 8'hFF);

      press(4'b1000);
      check_eq("mode_on", {31'd0, mode}, 32'h1);
      check_eq("mode_clears", {16'd0, count}, 32'h00);
      press(4'b0010);
      check_eq("hex_wrap_dn", {16'd0, count}, 32'hFF);
      check_display("hex", 8'h0E, 8'h8E);
      press(4'b0001);
      check_eq("hex_wrap_up", {16'd0, count}, 32'h00);
      press(4'b0001);
      check_eq("hex_inc", {16'd0, count}, 32'h01);
      press(4'b1100);
      check_eq("clr_mode_mode", {31'd0, mode}, 32'h0);
      check_eq("clr_mode_count", {16'd0, count}, 32'h00);

      press(4'b0001);
      press(4'b0001);
      check_eq("pre_rst_count", {16'd0, count}, 32'h02);
      btns = 4'b0001;
      tick(3);
      rst = 1'b1;
      #1;
      check_eq("midrst_an", {28'd0, an}, 32'hF);
      check_eq("midrst_c", {24'd0, c}, 32'hFF);
      check_eq("midrst_count", {16'd0, count}, 32'h0);
      tick(2);
      rst = 1'b0;
      tick(20);
      check_eq("held_no_press", {16'd0, count}, 32'h0);
      btns = 4'h0;
      tick(10);
      check_eq("release_no_press", {16'd0, count}, 32'h0);
      press(4'b0001);
      check_eq("repress", {16'd0, count}, 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
